store_buffer: RTL
=================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter XLEN, default `XLEN_64b, datapath width encoding; W = 1<<(XLEN+4) bits.
REQ-002 SHALL have parameter DEPTH, default 4, number of buffered stores (power of two, >=2).
REQ-003 SHALL have port i_clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_clk_enable  input  1  pipeline advance qualifier; gates every state update.
REQ-006 SHALL have port i_st_valid  input  1  store request from MEM stage.
REQ-007 SHALL have port o_st_ready  output  1  buffer can accept a store.
REQ-008 SHALL have port i_st_addr  input  W  store byte address.
REQ-009 SHALL have port i_st_data  input  W  store data, right-aligned.
REQ-010 SHALL have port i_st_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-011 SHALL have port i_ld_valid  input  1  load lookup request.
REQ-012 SHALL have port i_ld_addr  input  W  load byte address.
REQ-013 SHALL have port i_ld_size  input  2  same encoding as i_st_size.
REQ-014 SHALL have port o_ld_hit  output  1  load fully forwarded from buffer.
REQ-015 SHALL have port o_ld_data  output  W  forwarded data, zero-extended from load size.
REQ-016 SHALL have port o_ld_stall  output  1  partial overlap; load must wait.
REQ-017 SHALL have port i_mem_busy  input  1  data memory port claimed by a load this cycle.
REQ-018 SHALL have ports o_mem_write 1, o_mem_addr W, o_mem_data W, o_store_byte 1, o_store_half 1  outputs  drive data memory write port.
REQ-019 SHALL have port o_count  output  clog2(DEPTH)+1  occupied entries.

Function
REQ-020 SHALL hold entries {addr, data, size} in a circular FIFO with head/tail pointers wrapping modulo DEPTH.
REQ-021 SHALL assert o_st_ready = (o_count < DEPTH); no same-cycle fall-through when full.
REQ-022 SHALL push on rising edge when i_clk_enable & i_st_valid & o_st_ready; size 11 stored as 10.
REQ-023 SHALL drive o_mem_addr/o_mem_data/size decode combinationally from head entry; o_store_byte = (size==00), o_store_half = (size==01).
REQ-024 SHALL assert o_mem_write = (o_count!=0) & !i_mem_busy; pop head on rising edge when o_mem_write & i_clk_enable.
REQ-025 SHALL keep o_count unchanged on simultaneous push and pop; push allowed only per REQ-021.
REQ-026 SHALL hold all state when i_clk_enable=0; o_mem_write may assert but no pop occurs.
REQ-027 SHALL, for i_ld_valid=1, compare load byte range [addr, addr+n) against every valid entry, n = 1/2/4 by size; full-width compare, no address wrap.
REQ-028 SHALL select the youngest overlapping entry; o_ld_hit=1 iff its addr equals i_ld_addr and its size >= load size; o_ld_data = entry data masked to load size.
REQ-029 SHALL assert o_ld_stall=1 when any overlap exists and REQ-028 hit condition fails; o_ld_hit=0 then.
REQ-030 SHALL drive o_ld_hit=0, o_ld_stall=0, o_ld_data=0 when no overlap or i_ld_valid=0.
REQ-031 SHALL include the entry being popped this cycle in lookup (entry valid until the edge).
REQ-032 SHALL compute all lookup and memory outputs combinationally (zero-cycle latency); store-to-memory latency >= 1 cycle.

Reset
REQ-033 SHALL on i_rst=0, immediately and asynchronously, clear pointers and o_count to 0, giving o_st_ready=1, o_mem_write=0, o_ld_hit=0, o_ld_stall=0.
REQ-034 SHALL discard pending stores on reset mid-drain; entry contents need not be cleared.

Verification
REQ-035 Push word 0xDEADBEEF @0x100, i_mem_busy=0 -> next cycle o_mem_write=1, o_mem_addr=0x100, o_store_byte=0, o_store_half=0; following edge o_count=0.
REQ-036 i_mem_busy=1, push DEPTH stores -> o_count=DEPTH, o_st_ready=0; 5th push ignored; release busy -> drains in order, one per cycle, pointers wrap.
REQ-037 Full buffer, i_mem_busy=0, i_st_valid=1 -> pop occurs, push rejected that cycle, accepted next cycle.
REQ-038 Stores word 0x11223344 then byte 0xAA @0x200; load byte @0x200 -> o_ld_hit=1, o_ld_data=0xAA; load word @0x200 -> o_ld_stall=1.
REQ-039 Buffered half @0x302; load word @0x300 -> o_ld_stall=1; load byte @0x310 -> hit=0, stall=0.
REQ-040 Three stores buffered, assert i_rst=0 between edges -> o_count=0, o_mem_write=0 immediately; no further memory writes.

Source files
------------

// File: rtl/store_buffer.sv
// Post-MEM store buffer: a circular FIFO of pending stores that drains into the data memory port.
// Loads are checked against every buffered store and either get their data forwarded or are stalled.
`ifndef XLEN_32b
`define XLEN_32b 1
`endif
`ifndef XLEN_64b
`define XLEN_64b 2
`endif

module store_buffer #(
    parameter int XLEN  = `XLEN_64b,
    parameter int DEPTH = 4,
    localparam int W     = 1 << (XLEN + 4),
    localparam int AW    = W + 1,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clk_enable,
    input  logic             i_st_valid,
    output logic             o_st_ready,
    input  logic [W-1:0]     i_st_addr,
    input  logic [W-1:0]     i_st_data,
    input  logic [1:0]       i_st_size,
    input  logic             i_ld_valid,
    input  logic [W-1:0]     i_ld_addr,
    input  logic [1:0]       i_ld_size,
    output logic             o_ld_hit,
    output logic [W-1:0]     o_ld_data,
    output logic             o_ld_stall,
    input  logic             i_mem_busy,
    output logic             o_mem_write,
    output logic [W-1:0]     o_mem_addr,
    output logic [W-1:0]     o_mem_data,
    output logic             o_store_byte,
    output logic             o_store_half,
    output logic [CNT_W-1:0] o_count
);

    function automatic logic [1:0] size_norm(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b00;
            2'b01:   return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] s);
        case (s)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [W-1:0] size_mask(input logic [1:0] s);
        case (s)
            2'b00:   return W'(32'h0000_00FF);
            2'b01:   return W'(32'h0000_FFFF);
            default: return W'(32'hFFFF_FFFF);
        endcase
    endfunction

    logic [W-1:0]     ent_addr_r [DEPTH];
    logic [W-1:0]     ent_data_r [DEPTH];
    logic [1:0]       ent_size_r [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;

    logic             push_s;
    logic             pop_s;
    logic             found_s;
    logic [PTR_W-1:0] sel_s;
    logic [PTR_W-1:0] idx_s;
    logic [AW-1:0]    ld_lo_s;
    logic [AW-1:0]    ld_hi_s;
    logic [AW-1:0]    ent_lo_s;
    logic [AW-1:0]    ent_hi_s;

    assign o_st_ready   = (count_r < CNT_W'(DEPTH));
    assign o_mem_write  = (count_r != {CNT_W{1'b0}}) && !i_mem_busy;
    assign push_s       = i_st_valid && o_st_ready;
    assign pop_s        = o_mem_write;
    assign o_count      = count_r;
    assign o_mem_addr   = ent_addr_r[head_r];
    assign o_mem_data   = ent_data_r[head_r];
    assign o_store_byte = (ent_size_r[head_r] == 2'b00);
    assign o_store_half = (ent_size_r[head_r] == 2'b01);

    // FIFO pointers and occupancy; a push and pop in the same cycle leave the count unchanged
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (i_clk_enable) begin
            if (push_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry payload storage; contents survive reset since occupancy alone defines validity
    always_ff @(posedge i_clk) begin
        if (i_clk_enable && push_s) begin
            ent_addr_r[tail_r] <= i_st_addr;
            ent_data_r[tail_r] <= i_st_data;
            ent_size_r[tail_r] <= size_norm(i_st_size);
        end
    end

    // Walk entries oldest to youngest so the last overlap found is the youngest one
    always_comb begin
        found_s  = 1'b0;
        sel_s    = head_r;
        idx_s    = head_r;
        ent_lo_s = {AW{1'b0}};
        ent_hi_s = {AW{1'b0}};
        ld_lo_s  = {1'b0, i_ld_addr};
        ld_hi_s  = ld_lo_s + AW'(size_bytes(i_ld_size));
        for (int j = 0; j < DEPTH; j++) begin
            idx_s    = head_r + PTR_W'(j);
            ent_lo_s = {1'b0, ent_addr_r[idx_s]};
            ent_hi_s = ent_lo_s + AW'(size_bytes(ent_size_r[idx_s]));
            if ((CNT_W'(j) < count_r) && (ld_lo_s < ent_hi_s) && (ent_lo_s < ld_hi_s)) begin
                found_s = 1'b1;
                sel_s   = idx_s;
            end else begin
                found_s = found_s;
                sel_s   = sel_s;
            end
        end
    end

    // Forward only when the youngest overlapping store covers the load exactly from its first byte
    always_comb begin
        o_ld_hit   = 1'b0;
        o_ld_stall = 1'b0;
        o_ld_data  = {W{1'b0}};
        if (i_ld_valid && found_s) begin
            if ((ent_addr_r[sel_s] == i_ld_addr) &&
                (ent_size_r[sel_s] >= size_norm(i_ld_size))) begin
                o_ld_hit  = 1'b1;
                o_ld_data = ent_data_r[sel_s] & size_mask(i_ld_size);
            end else begin
                o_ld_stall = 1'b1;
            end
        end else begin
            o_ld_hit = 1'b0;
        end
    end

endmodule
